// File: rtl/logic_ops_serial_if.sv
// Handshake bundle for logic_ops_serial: operand/op input channel and result output channel.
interface logic_ops_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, neg
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, neg
    );
endinterface

// File: rtl/logic_ops_serial.sv
// Chunk-serial logical-ops unit with valid/ready handshakes on both sides.
// Optional zero/neg result flags are enabled by defining LOGIC_OPS_SERIAL_FLAGS_EN.
module logic_ops_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst_n,
    logic_ops_serial_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_res;
    logic             carry_out;
    logic [WIDTH-1:0] result_busy;
    logic             last_edge;

    always_comb begin
        a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_res = '0;
        carry_out = 1'b0;
        case (op_q)
            3'b000:  chunk_res = a_chunk & b_chunk;
            3'b001:  chunk_res = a_chunk | b_chunk;
            3'b010:  chunk_res = ~a_chunk;
            3'b011:  chunk_res = a_chunk ^ b_chunk;
            3'b100:  chunk_res = ~(a_chunk & b_chunk);
            3'b101:  chunk_res = ~(a_chunk | b_chunk);
            3'b110:  chunk_res = ~(a_chunk ^ b_chunk);
            // Negation: invert and ripple the +1 across chunks via carry_q.
            default: {carry_out, chunk_res} = {1'b0, ~a_chunk} + {{CHUNK{1'b0}}, carry_q};
        endcase
    end

    // Only the chunk selected by idx_q is replaced; the rest keep their current value.
    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign result_busy[gi*CHUNK +: CHUNK] =
                (idx_q == IDXW'(gi)) ? chunk_res : result_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign last_edge    = (state_q == BUSY) && (idx_q == IDXW'(NCHUNK - 1));
    assign bus.in_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    op_d     = bus.op;
                    result_d = '0;
                    idx_d    = '0;
                    carry_d  = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                result_d = result_busy;
                carry_d  = carry_out;
                idx_d    = idx_q + 1'b1;
                if (last_edge) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;

`ifdef LOGIC_OPS_SERIAL_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;

    // Flags are taken from the fully assembled result on the final BUSY edge.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (last_edge) begin
            zero_d = (result_busy == '0);
            neg_d  = result_busy[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
`else
    assign bus.zero = 1'b0;
    assign bus.neg  = 1'b0;
`endif
endmodule

// File: tb/tb_logic_ops_serial.sv
// Directed bench for logic_ops_serial: vector table on a 16/4 instance plus
// backpressure, mid-op reset, and 32/8 and 8/8 parametrisations.
module tb_logic_ops_serial;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_ops_serial_if #(.WIDTH(16)) v16();
    logic_ops_serial_if #(.WIDTH(32)) v32();
    logic_ops_serial_if #(.WIDTH(8))  v8();

    logic_ops_serial #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(v16.slave));
    logic_ops_serial #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(v32.slave));
    logic_ops_serial #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(v8.slave));

`ifdef LOGIC_OPS_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at the negedge after the accept edge; counts edges until out_valid.
    task automatic wait_done16(output int lat);
        lat = 0;
        while (v16.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic txn16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp);
        int lat;
        @(negedge clk);
        check("in_ready_idle", 32'(v16.in_ready), 32'd1);
        v16.op        = o;
        v16.a         = av;
        v16.b         = bv;
        v16.in_valid  = 1'b1;
        v16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v16.in_valid = 1'b0;
        wait_done16(lat);
        check("latency", 32'(lat), 32'd4);
        check("result", 32'(v16.result), 32'(exp));
        check("zero", 32'(v16.zero), 32'(FLAGS && (exp == 16'h0000)));
        check("neg", 32'(v16.neg), 32'(FLAGS && exp[15]));
        $display("[TB] op=%b a=%h b=%h result=%h expected=%h lat=%0d", o, av, bv, v16.result, exp, lat);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{3'b111, 16'hFFFF, 16'h2495, 16'h0001};
        vecs[1]  = '{3'b000, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[2]  = '{3'b011, 16'hF0F0, 16'hFF00, 16'h0FF0};
        vecs[3]  = '{3'b110, 16'hF0F0, 16'hFF00, 16'hF00F};
        vecs[4]  = '{3'b010, 16'h00FF, 16'h1234, 16'hFF00};
        vecs[5]  = '{3'b111, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[6]  = '{3'b111, 16'h0001, 16'h0000, 16'hFFFF};
        vecs[7]  = '{3'b111, 16'h8000, 16'h0000, 16'h8000};
        vecs[8]  = '{3'b111, 16'h0010, 16'h0000, 16'hFFF0};
        vecs[9]  = '{3'b001, 16'hF0F0, 16'h0F0F, 16'hFFFF};
        vecs[10] = '{3'b100, 16'hF0F0, 16'hFF00, 16'h0FFF};
        vecs[11] = '{3'b101, 16'hF0F0, 16'hFF00, 16'h000F};
        vecs[12] = '{3'b111, 16'h1234, 16'h5555, 16'hEDCC};

        rst_n = 1'b0;
        v16.in_valid = 1'b0; v16.a = '0; v16.b = '0; v16.op = '0; v16.out_ready = 1'b0;
        v32.in_valid = 1'b0; v32.a = '0; v32.b = '0; v32.op = '0; v32.out_ready = 1'b0;
        v8.in_valid  = 1'b0; v8.a  = '0; v8.b  = '0; v8.op  = '0; v8.out_ready  = 1'b0;
        #1;
        check("rst_in_ready", 32'(v16.in_ready), 32'd1);
        check("rst_out_valid", 32'(v16.out_valid), 32'd0);
        check("rst_result", 32'(v16.result), 32'd0);
        check("rst_zero", 32'(v16.zero), 32'd0);
        check("rst_neg", 32'(v16.neg), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            txn16(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure: new operand offered while DONE must not be captured.
        @(negedge clk);
        v16.op = 3'b000; v16.a = 16'hFFFF; v16.b = 16'h00FF;
        v16.in_valid = 1'b1; v16.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v16.op = 3'b011; v16.a = 16'hAAAA; v16.b = 16'hFFFF;
        wait_done16(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int k = 0; k < 3; k++) begin
            check("bp_result_hold", 32'(v16.result), 32'h00FF);
            check("bp_in_ready", 32'(v16.in_ready), 32'd0);
            check("bp_out_valid", 32'(v16.out_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_result_after_hold", 32'(v16.result), 32'h00FF);
        $display("[TB] backpressure held result=%h", v16.result);
        v16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_out_valid_fall", 32'(v16.out_valid), 32'd0);
        check("bp_in_ready_back", 32'(v16.in_ready), 32'd1);
        check("bp_result_kept", 32'(v16.result), 32'h00FF);
        @(posedge clk);
        @(negedge clk);
        v16.in_valid = 1'b0;
        wait_done16(lat);
        check("bp_new_latency", 32'(lat), 32'd4);
        check("bp_new_result", 32'(v16.result), 32'h5555);
        $display("[TB] backpressure follow-up op=011 result=%h lat=%0d", v16.result, lat);

        // Reset during the second BUSY cycle.
        @(negedge clk);
        v16.op = 3'b000; v16.a = 16'hFFFF; v16.b = 16'hFFFF; v16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v16.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("partial_result", 32'(v16.result), 32'h000F);
        rst_n = 1'b0;
        #1;
        check("abort_result", 32'(v16.result), 32'd0);
        check("abort_out_valid", 32'(v16.out_valid), 32'd0);
        check("abort_in_ready", 32'(v16.in_ready), 32'd1);
        check("abort_zero", 32'(v16.zero), 32'd0);
        check("abort_neg", 32'(v16.neg), 32'd0);
        $display("[TB] reset mid-op result=%h in_ready=%b", v16.result, v16.in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        txn16(3'b101, 16'hFFFF, 16'h0000, 16'h0000);

        // WIDTH=32, CHUNK=8 negation.
        @(negedge clk);
        v32.op = 3'b111; v32.a = 32'h00000001; v32.b = 32'h0; v32.in_valid = 1'b1; v32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32.in_valid = 1'b0;
        lat = 0;
        while (v32.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("w32_latency", 32'(lat), 32'd4);
        check("w32_result", v32.result, 32'hFFFFFFFF);
        $display("[TB] w32 op=111 a=00000001 result=%h lat=%0d", v32.result, lat);

        // WIDTH=8, CHUNK=8: single BUSY cycle.
        @(negedge clk);
        v8.op = 3'b100; v8.a = 8'hAA; v8.b = 8'hFF; v8.in_valid = 1'b1; v8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v8.in_valid = 1'b0;
        lat = 0;
        while (v8.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("w8_latency", 32'(lat), 32'd1);
        check("w8_result", 32'(v8.result), 32'h55);
        $display("[TB] w8 op=100 a=AA b=FF result=%h lat=%0d", v8.result, lat);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
